xor_display_ctrl: RTL
=====================

XOR_DISPLAY_CTRL -- requirements
Module: xor_display_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed 7-segment digits (legal range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 12500, clock cycles per digit slot (legal when SCAN_DIV >= BLANK_CYC+2).
REQ-003 SHALL have parameter BLANK_CYC, default 250, anti-ghost cycles at each slot start with all anodes off.
REQ-004 SHALL have parameter DB_CYCLES, default 500000, cycles a synchronised button level must hold to be accepted (>=2).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1; 1 = segments and anodes driven low-active, 0 = high-active.
REQ-006 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have ports btn_1, btn_2  input  1 each  raw asynchronous push-buttons, high = pressed.
REQ-009 SHALL have port digit_data  input  4*N_DIGITS  hex nibble per digit, digit i at bits [4i+3:4i].
REQ-010 SHALL have port blank_mask  input  N_DIGITS  1 = digit i shows all segments off.
REQ-011 SHALL have port dp_mask  input  N_DIGITS  1 = decimal point of digit i lit.
REQ-012 SHALL have ports x1, x2  output  1 each  toggled network inputs driven by btn_1 / btn_2.
REQ-013 SHALL have port x_valid  output  1  single-cycle pulse when x1 or x2 changes.
REQ-014 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
REQ-015 SHALL have port dp  output  1  decimal point.
REQ-016 SHALL have port an  output  N_DIGITS  digit enables, one-hot active when driven.

Function
REQ-017 Each button SHALL pass a two-flop synchroniser before any other logic.
REQ-018 Per-button debounce counter SHALL clear whenever synchronised level equals accepted level, otherwise increment; on reaching DB_CYCLES-1 the accepted level SHALL update and counter clear.
REQ-019 A glitch shorter than DB_CYCLES cycles SHALL never change the accepted level.
REQ-020 A 0->1 transition of accepted level SHALL toggle the matching x output on the next clock; 1->0 SHALL have no effect.
REQ-021 x_valid SHALL be high for exactly the cycle in which x1/x2 show their new value; simultaneous toggles of both SHALL give one pulse.
REQ-022 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-023 While prescaler < BLANK_CYC all anodes SHALL be inactive; otherwise only an[index] SHALL be active.
REQ-024 seg SHALL show the standard hex 0-F decode of the current digit nibble; blanked digit SHALL drive all segments inactive; dp SHALL follow dp_mask[index].
REQ-025 seg, dp, an SHALL be registered; a change on digit_data SHALL appear on seg one clock later.
REQ-026 Polarity: with ACTIVE_LOW=1, lit segment / enabled anode = 0; with ACTIVE_LOW=0, = 1.
REQ-027 With N_DIGITS=1 the index SHALL stay 0 and blanking SHALL still apply each slot.

Reset
REQ-028 While rst_n=0: x1=0, x2=0, x_valid=0, prescaler=0, index=0, debounce counters=0, accepted levels=0, synchronisers=0, all anodes and segments and dp inactive.
REQ-029 Reset asserted mid-press or mid-slot SHALL discard all progress; after release, a still-held button SHALL need a full DB_CYCLES to be accepted and SHALL then toggle.

Verification (N_DIGITS=4, SCAN_DIV=16, BLANK_CYC=2, DB_CYCLES=8, ACTIVE_LOW=1)
REQ-030 Reset release, digit_data=16'h3210, masks 0 -> anodes cycle 4'b1110,1101,1011,0111 each for 14 cycles after 2 all-1 cycles; seg for digit 0 = 7'b1000000.
REQ-031 btn_1 high 20 cycles -> x1=1 with one x_valid pulse about 2+8+1 cycles after press; release -> no change; second press -> x1=0.
REQ-032 btn_2 pulses high 5 cycles, low 3, repeated -> x2 stays 0, x_valid never asserts.
REQ-033 btn_1 and btn_2 rise same cycle, held -> x1=x2=1 same cycle, exactly one x_valid pulse.
REQ-034 blank_mask=4'b0100, dp_mask=4'b0001 -> slot 2 seg=7'h7F; dp=0 only in slot 0.
REQ-035 rst_n pulsed low at debounce count 5 during held btn_1 -> all outputs at reset values; x1 toggles only after 8 further stable cycles.

Source files
------------

// File: rtl/xor_display_ctrl.sv
`timescale 1ns/1ps
// Debounced push-buttons toggle the x1/x2 network inputs; a scanned driver shows N_DIGITS hex nibbles.
// Latency: x toggles 2+DB_CYCLES+1 cycles after a press; seg/dp/an are registered one cycle; no backpressure.
module xor_display_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 12500,
    parameter int BLANK_CYC  = 250,
    parameter int DB_CYCLES  = 500000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_1,
    input  logic                  btn_2,
    input  logic [4*N_DIGITS-1:0] digit_data,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic                  x1,
    output logic                  x2,
    output logic                  x_valid,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]       BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [DW-1:0]       DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [6:0]          SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic                DP_OFF     = ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{ACTIVE_LOW}};

    // Button path state, bit 0 = btn_1, bit 1 = btn_2
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         acc_q, acc_d;
    logic [1:0]         acc_prev_q, acc_prev_d;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]         x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic [1:0]         rise;

    // Display path state
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic                cur_dp;
    logic                in_blank;
    logic [6:0]          seg_on;
    logic [N_DIGITS-1:0] an_on;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        sync1_d    = {btn_2, btn_1};
        sync2_d    = sync1_q;
        acc_prev_d = acc_q;
        acc_d      = acc_q;
        db_cnt_d   = db_cnt_q;
        // Counter only runs while the synchronised level disagrees with the accepted one
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == acc_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
                acc_d[b]    = sync2_q[b];
                db_cnt_d[b] = '0;
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + DW'(1);
            end
        end
        rise      = acc_q & ~acc_prev_q;
        x_d       = x_q ^ rise;
        x_valid_d = |rise;
    end

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        in_blank  = (presc_q < BLANK_END);
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        an_on     = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = digit_data[4*i +: 4];
                cur_blank = blank_mask[i];
                cur_dp    = dp_mask[i];
                an_on[i]  = !in_blank;
            end
        end

        seg_on = cur_blank ? 7'h00 : hex7(cur_nib);
        seg_d  = seg_on ^ SEG_OFF;
        dp_d   = cur_dp ^ DP_OFF;
        an_d   = an_on ^ AN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            db_cnt_q   <= '0;
            x_q        <= '0;
            x_valid_q  <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            an_q       <= AN_OFF;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            acc_prev_q <= acc_prev_d;
            db_cnt_q   <= db_cnt_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign x1      = x_q[0];
    assign x2      = x_q[1];
    assign x_valid = x_valid_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;

endmodule
